wb_interconnect: RTL and testbench

WB_INTERCONNECT -- requirements
Module: wb_interconnect

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_rr_arbiter.sv | 21 ++
 rtl/wb_interconnect.sv | 140 ++++++++++++++
 tb/tb_wb_interconnect.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the two-controller Wishbone-style interconnect.
package wb_pkg;

  localparam int SlotW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-request round-robin arbiter: a lone requester wins, a tie goes to the
// controller that was not granted last.
module wb_rr_arbiter
  import wb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/wb_interconnect.sv
// Routes one of two controllers to one of NPeri peripheral slots at a time,
// with round-robin arbitration, unmapped-slot completion and an ack timeout.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int AddrW   = 8,
  parameter int DataW   = 8,
  parameter int NPeri   = 4,
  parameter int Timeout = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             m_stb_i,
  input  logic [1:0]             m_we_i,
  input  logic [2*AddrW-1:0]     m_adr_i,
  input  logic [2*DataW-1:0]     m_dat_i,
  output logic [DataW-1:0]       m_dat_o,
  output logic [1:0]             m_ack_o,
  output logic [NPeri-1:0]       p_stb_o,
  output logic                   p_we_o,
  output logic [AddrW-SlotW-1:0] p_adr_o,
  output logic [DataW-1:0]       p_dat_o,
  input  logic [NPeri*DataW-1:0] p_dat_i,
  input  logic [NPeri-1:0]       p_ack_i,
  output logic                   err_o,
  output logic                   busy_o
);

  state_t           state;
  logic [SlotW-1:0] slot;
  logic [7:0]       cnt;
  logic             gnt_idx;
  logic             last_grant;
  logic [1:0]       gnt;

  logic             sel_idx;
  logic             sel_we;
  logic [AddrW-1:0] sel_adr;
  logic [DataW-1:0] sel_dat;
  logic [SlotW-1:0] sel_slot;
  logic             sel_mapped;
  logic [15:0]      ack_pad;
  logic             ack_sel;
  logic [DataW-1:0] dat_sel;

  wb_rr_arbiter u_arb (
    .req        (m_stb_i),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  assign sel_idx    = gnt[1];
  assign sel_we     = sel_idx ? m_we_i[1] : m_we_i[0];
  assign sel_adr    = sel_idx ? m_adr_i[2*AddrW-1:AddrW] : m_adr_i[AddrW-1:0];
  assign sel_dat    = sel_idx ? m_dat_i[2*DataW-1:DataW] : m_dat_i[DataW-1:0];
  assign sel_slot   = sel_adr[AddrW-1 -: SlotW];
  assign sel_mapped = int'(sel_slot) < NPeri;

  // Padding to 16 lets the 4-bit slot index the ack vector for any NPeri.
  assign ack_pad = 16'(p_ack_i);
  assign ack_sel = ack_pad[slot];

  always_comb begin
    dat_sel = '0;
    for (int i = 0; i < NPeri; i++) begin
      if (slot == SlotW'(i)) dat_sel = p_dat_i[i*DataW +: DataW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      slot       <= '0;
      cnt        <= '0;
      gnt_idx    <= 1'b0;
      last_grant <= 1'b1;
      m_dat_o    <= '0;
      m_ack_o    <= 2'b00;
      p_stb_o    <= '0;
      p_we_o     <= 1'b0;
      p_adr_o    <= '0;
      p_dat_o    <= '0;
      err_o      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      m_ack_o <= 2'b00;
      err_o   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|m_stb_i) begin
            gnt_idx    <= sel_idx;
            last_grant <= sel_idx;
            p_we_o     <= sel_we;
            p_adr_o    <= sel_adr[AddrW-SlotW-1:0];
            p_dat_o    <= sel_dat;
            slot       <= sel_slot;
            cnt        <= '0;
            busy_o     <= 1'b1;
            if (sel_mapped) begin
              state   <= ST_BUSY;
              p_stb_o <= NPeri'(1) << sel_slot;
            end else begin
              state   <= ST_ACK;
              m_dat_o <= '0;
              m_ack_o <= gnt;
            end
          end
        end
        ST_BUSY: begin
          // Ack is tested first so a same-cycle ack beats the timeout.
          if (ack_sel) begin
            m_dat_o <= dat_sel;
            p_stb_o <= '0;
            m_ack_o <= gnt_idx ? 2'b10 : 2'b01;
            state   <= ST_ACK;
          end else if (cnt == 8'(Timeout - 1)) begin
            m_dat_o <= '1;
            p_stb_o <= '0;
            m_ack_o <= gnt_idx ? 2'b10 : 2'b01;
            err_o   <= 1'b1;
            state   <= ST_ACK;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_ACK: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
        default: begin
          state   <= ST_IDLE;
          p_stb_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Randomized and directed bench for wb_interconnect against a transaction-level
// timing model of grant order, strobe window, ack cycle and returned data.
module tb_wb_interconnect;

  localparam int TO = 255;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [1:0]  m_stb_i = '0;
  logic [1:0]  m_we_i = '0;
  logic [15:0] m_adr_i = '0;
  logic [15:0] m_dat_i = '0;
  logic [7:0]  m_dat_o;
  logic [1:0]  m_ack_o;
  logic [3:0]  p_stb_o;
  logic        p_we_o;
  logic [3:0]  p_adr_o;
  logic [7:0]  p_dat_o;
  logic [31:0] p_dat_i;
  logic [3:0]  p_ack_i;
  logic        err_o;
  logic        busy_o;

  wb_interconnect #(.AddrW(8), .DataW(8), .NPeri(4), .Timeout(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .p_stb_o(p_stb_o), .p_we_o(p_we_o), .p_adr_o(p_adr_o), .p_dat_o(p_dat_o),
    .p_dat_i(p_dat_i), .p_ack_i(p_ack_i), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Peripheral models: ack arrives dly[s] cycles into the strobe; idle slots babble.
  int         dly [4];
  logic [7:0] pd  [4];
  int         age [4];
  logic [3:0] noise = '0;

  always @(posedge clk_i) begin
    for (int s = 0; s < 4; s++) age[s] <= p_stb_o[s] ? age[s] + 1 : 0;
    noise <= 4'($urandom);
  end

  always_comb begin
    p_ack_i = '0;
    p_dat_i = '0;
    for (int s = 0; s < 4; s++) begin
      p_ack_i[s] = p_stb_o[s] ? (age[s] >= dly[s]) : noise[s];
      p_dat_i[s*8 +: 8] = pd[s];
    end
  end

  typedef struct {
    int         ctrl;
    int         slot;
    int         ncyc;
    int         g;
    int         ackc;
    bit         err;
    bit         we;
    logic [3:0] padr;
    logic [7:0] pdat;
    logic [7:0] mdat;
  } txn_t;

  txn_t q[$];
  int   last_model = 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // Observations recorded at each ack for the literal checks.
  int         obs_ack_cyc, obs_stb_len, run_len;
  logic [7:0] obs_dat;
  logic [3:0] obs_padr;
  logic       obs_err;
  int         hist[$];

  txn_t       t;
  logic [3:0] e_stb;
  logic [1:0] e_ack;
  logic       e_err, e_busy, active;

  initial forever begin
    @(negedge clk_i);
    if (!rst_ni) begin
      run_len = 0;
    end else begin
      while (q.size() > 0 && q[0].ackc < cyc) void'(q.pop_front());
      e_stb = '0; e_ack = '0; e_err = 1'b0; e_busy = 1'b0; active = 1'b0;
      if (q.size() > 0 && cyc >= q[0].g) begin
        t = q[0];
        active = 1'b1;
        e_busy = 1'b1;
        if (cyc < t.g + t.ncyc) e_stb = 4'(1) << t.slot;
        if (cyc == t.ackc) begin
          e_ack = 2'(1) << t.ctrl;
          e_err = t.err;
        end
      end
      chk("p_stb", 32'(p_stb_o), 32'(e_stb));
      chk("m_ack", 32'(m_ack_o), 32'(e_ack));
      chk("err", 32'(err_o), 32'(e_err));
      chk("busy", 32'(busy_o), 32'(e_busy));
      if (active) begin
        chk("p_adr", 32'(p_adr_o), 32'(t.padr));
        chk("p_we", 32'(p_we_o), 32'(t.we));
        chk("p_dat", 32'(p_dat_o), 32'(t.pdat));
        if (e_ack != 0) chk("m_dat", 32'(m_dat_o), 32'(t.mdat));
      end
      if (p_stb_o != 0) run_len++;
      if (m_ack_o != 0) begin
        obs_ack_cyc = cyc;
        obs_stb_len = run_len;
        obs_dat     = m_dat_o;
        obs_padr    = p_adr_o;
        obs_err     = err_o;
        hist.push_back(m_ack_o[1] ? 1 : 0);
        run_len = 0;
      end
    end
  end

  // Issue one round of requests; the model predicts each grant from the rules.
  task automatic run_round(input logic [1:0] mask, input logic [1:0] we,
                           input logic [15:0] adr, input logic [15:0] dat,
                           input bit drop_early, output int g0);
    int order[$];
    int g, i, slot, n;
    logic [1:0] pending;
    txn_t nt;
    @(negedge clk_i);
    g  = cyc + 1;
    g0 = g;
    if (mask == 2'b11) begin
      i = (last_model == 1) ? 0 : 1;
      order = '{i, 1 - i};
    end else begin
      order = '{mask[1] ? 1 : 0};
    end
    foreach (order[k]) begin
      i = order[k];
      slot = int'(adr[i*8+4 +: 4]);
      nt.ctrl = i;
      nt.slot = slot;
      nt.we   = we[i];
      nt.padr = adr[i*8 +: 4];
      nt.pdat = dat[i*8 +: 8];
      nt.g    = g;
      if (slot < 4) begin
        nt.ncyc = (dly[slot] + 1 < TO) ? dly[slot] + 1 : TO;
        nt.err  = dly[slot] >= TO;
        nt.mdat = nt.err ? 8'hFF : pd[slot];
      end else begin
        nt.ncyc = 0;
        nt.err  = 1'b0;
        nt.mdat = 8'h00;
      end
      nt.ackc = g + nt.ncyc;
      q.push_back(nt);
      last_model = i;
      g = nt.ackc + 2;
    end
    m_stb_i = mask; m_we_i = we; m_adr_i = adr; m_dat_i = dat;
    pending = mask;
    n = 0;
    while (pending != 0 && n < 700) begin
      @(negedge clk_i);
      n++;
      if (drop_early && n == 1) m_stb_i = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (m_ack_o[c]) begin
          pending[c] = 1'b0;
          m_stb_i[c] = 1'b0;
        end
      end
    end
    if (pending != 0) begin
      checks++;
      errors++;
      $display("FAIL round_timeout cyc=%0d got=pending %0b exp=0", cyc, pending);
      m_stb_i = 2'b00;
    end
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  int g0, h0, gr;
  logic [1:0]  rmask, rwe;
  logic [15:0] radr, rdat;

  initial begin
    for (int s = 0; s < 4; s++) begin
      dly[s] = 0;
      pd[s]  = 8'(8'h11 * (s + 1));
    end
    repeat (3) @(negedge clk_i);
    chk("rst_p_stb", 32'(p_stb_o), 0);
    chk("rst_m_ack", 32'(m_ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_m_dat", 32'(m_dat_o), 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_p_adr", 32'(p_adr_o), 0);
    chk("rst_p_dat", 32'(p_dat_o), 0);
    chk("rst_err", 32'(err_o), 0);

    // Both controllers strobe from reset: grants must alternate 0,1,0,1.
    h0 = hist.size();
    run_round(2'b11, 2'b00, 16'h1201, 16'hB0A0, 1'b0, g0);
    run_round(2'b11, 2'b11, 16'h3302, 16'hD0C0, 1'b0, g0);
    chk("rr_count", 32'(hist.size() - h0), 4);
    if (hist.size() >= h0 + 4)
      for (int k = 0; k < 4; k++) chk("rr_order", 32'(hist[h0+k]), 32'(k % 2));

    // m0 read 0x03, slot 0 acks immediately.
    pd[0] = 8'h5A;
    run_round(2'b01, 2'b00, 16'h0003, 16'h0000, 1'b0, g0);
    chk("lat_mapped", 32'(obs_ack_cyc - g0), 1);
    chk("dat_mapped", 32'(obs_dat), 32'h5A);
    chk("padr_mapped", 32'(obs_padr), 32'h3);
    chk("stb_len_mapped", 32'(obs_stb_len), 1);

    // m1 write to unmapped slot 7.
    run_round(2'b10, 2'b10, 16'h7F00, 16'h9900, 1'b0, g0);
    chk("lat_unmapped", 32'(obs_ack_cyc - g0), 0);
    chk("dat_unmapped", 32'(obs_dat), 0);
    chk("err_unmapped", 32'(obs_err), 0);
    chk("stb_len_unmapped", 32'(obs_stb_len), 0);
    chk("ack_ctrl_unmapped", 32'(hist[hist.size()-1]), 1);

    // Slot 2 never acks: full timeout; strobe dropped early must not abort.
    dly[2] = 1000;
    run_round(2'b01, 2'b00, 16'h0025, 16'h0000, 1'b1, g0);
    chk("stb_len_timeout", 32'(obs_stb_len), 255);
    chk("dat_timeout", 32'(obs_dat), 32'hFF);
    chk("err_timeout", 32'(obs_err), 1);
    chk("lat_timeout", 32'(obs_ack_cyc - g0), 255);

    // Ack on the last allowed cycle wins over the timeout.
    dly[2] = TO - 1;
    pd[2]  = 8'h3C;
    run_round(2'b01, 2'b00, 16'h0021, 16'h0000, 1'b0, g0);
    chk("stb_len_edge", 32'(obs_stb_len), 255);
    chk("dat_edge", 32'(obs_dat), 32'h3C);
    chk("err_edge", 32'(obs_err), 0);

    for (int r = 0; r < 70; r++) begin
      for (int s = 0; s < 4; s++) begin
        gr = $urandom_range(0, 59);
        dly[s] = (gr == 0) ? 400 : (gr == 1) ? TO - 1 : gr % 4;
        pd[s]  = 8'($urandom);
      end
      rmask = 2'($urandom_range(1, 3));
      rwe   = 2'($urandom);
      radr  = {4'($urandom_range(0, 5)), 4'($urandom), 4'($urandom_range(0, 5)), 4'($urandom)};
      rdat  = 16'($urandom);
      run_round(rmask, rwe, radr, rdat, 1'b0, g0);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    // Reset during the fifth BUSY cycle of a slot-2 read.
    dly[2] = 1000;
    @(negedge clk_i);
    g0 = cyc + 1;
    t.ctrl = 0; t.slot = 2; t.we = 1'b0; t.padr = 4'h0; t.pdat = 8'h00;
    t.g = g0; t.ncyc = TO; t.err = 1'b1; t.mdat = 8'hFF; t.ackc = g0 + TO;
    q.push_back(t);
    m_stb_i = 2'b01; m_we_i = 2'b00; m_adr_i = 16'h0020; m_dat_i = 16'h0000;
    while (cyc < g0 + 4) @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    q.delete();
    #1;
    chk("rst_async_p_stb", 32'(p_stb_o), 0);
    chk("rst_async_m_ack", 32'(m_ack_o), 0);
    chk("rst_async_busy", 32'(busy_o), 0);
    m_stb_i = 2'b00;
    repeat (2) begin
      @(negedge clk_i);
      chk("rst_hold_m_ack", 32'(m_ack_o), 0);
      chk("rst_hold_p_stb", 32'(p_stb_o), 0);
    end
    rst_ni = 1'b1;
    last_model = 1;
    dly[1] = 0;
    h0 = hist.size();
    run_round(2'b11, 2'b00, 16'h1010, 16'h0000, 1'b0, g0);
    chk("post_rst_count", 32'(hist.size() - h0), 2);
    if (hist.size() > h0) chk("post_rst_first", 32'(hist[h0]), 0);

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
